// File: rtl/m_serdes_pkg.sv
// Shared types and helpers for the MPU serializer/deserializer blocks.
//   s2p_state_t : deserializer FSM state encoding
//   WORD_DEF    : default frame width in data bits
//   even_par    : XOR reduction of the low n bits of v (even-parity bit)
package m_serdes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } s2p_state_t;

  localparam int unsigned WORD_DEF = 8;

  // Even-parity bit over v[n-1:0]; bits at or above n are ignored.
  function automatic logic even_par(logic [31:0] v, int n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) p ^= v[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/m_s2p_hold.sv
// Single-entry valid/ready holding register for the deserializer output.
//   clk, reset (async, active-low)
//   clr       : sync clear of valid and ovf
//   load      : a frame completes this cycle, load_word is its value
//   load_word : completed word
//   ready     : consumer accepts word this cycle (ignored while valid=0)
//   word      : held word, stable while valid=1
//   valid     : register full
//   ovf       : sticky, a completed word was dropped because the register stayed full
module m_s2p_hold
  import m_serdes_pkg::*;
#(
  parameter int unsigned WORD = WORD_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            load,
  input  logic [WORD-1:0] load_word,
  input  logic            ready,
  output logic [WORD-1:0] word,
  output logic            valid,
  output logic            ovf
);

  logic pop_c;

  // A pop only counts while something is held.
  assign pop_c = valid & ready;

  // Load wins over pop at the same edge; a load into a full, unpopped register is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word  <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      if (!valid || pop_c) begin
        word  <= load_word;
        valid <= 1'b1;
      end else begin
        ovf <= 1'b1;
      end
    end else if (pop_c) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/m_s_to_p.sv
// Serial-to-parallel deserializer: assembles WORD MSB-first qualified bits into a
// word and presents it through a single-entry valid/ready holding register.
// Optional feature macro: S2P_PARITY_EN (adds one trailing even-parity bit per frame).
//   clk, reset (async, active-low)
//   clr        : sync clear, aborts the frame, drops the held word, clears ovf/parity_err
//   sin        : serial data, MSB first
//   sin_valid  : qualifies sin, one bit per cycle
//   word_o     : assembled word, stable while word_valid=1
//   word_valid : holding register full
//   word_ready : consumer accepts word_o
//   busy       : frame in progress
//   ovf        : sticky, completed frame dropped while full
//   parity_err : sticky parity mismatch (0 when S2P_PARITY_EN undefined)
module m_s_to_p
  import m_serdes_pkg::*;
#(
  parameter int unsigned WORD = WORD_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            sin,
  input  logic            sin_valid,
  output logic [WORD-1:0] word_o,
  output logic            word_valid,
  input  logic            word_ready,
  output logic            busy,
  output logic            ovf,
  output logic            parity_err
);

  localparam int unsigned CW = $clog2(WORD + 1);

  s2p_state_t      state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [WORD-1:0] sr, sr_next;
  logic [WORD-1:0] load_data_c;
  logic            load_c;
  logic            par_bad_c;

  // State, counter and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sr    <= sr_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Next-state, datapath and completion decode.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    sr_next     = sr;
    load_c      = 1'b0;
    load_data_c = sr;
    par_bad_c   = 1'b0;
    if (clr) begin
      state_next = IDLE;
      cnt_next   = '0;
      sr_next    = '0;
    end else if (sin_valid) begin
      case (state)
        IDLE: begin
          // Start a fresh frame so no stale bits from an earlier word survive.
          sr_next    = {{(WORD-1){1'b0}}, sin};
          cnt_next   = CW'(1);
          state_next = SHIFT;
        end
        SHIFT: begin
          sr_next = {sr[WORD-2:0], sin};
          if (cnt == CW'(WORD - 1)) begin
`ifdef S2P_PARITY_EN
            cnt_next   = CW'(WORD);
            state_next = PAR;
`else
            // Final data bit goes straight into the holding register this edge.
            cnt_next    = '0;
            state_next  = IDLE;
            load_c      = 1'b1;
            load_data_c = sr_next;
`endif
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
`ifdef S2P_PARITY_EN
        PAR: begin
          // Parity bit is not data; sr already holds the complete word.
          cnt_next    = '0;
          state_next  = IDLE;
          load_c      = 1'b1;
          load_data_c = sr;
          par_bad_c   = (sin != even_par(32'(sr), int'(WORD)));
        end
`endif
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef S2P_PARITY_EN
  // Sticky parity error; the word is still delivered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
    end else if (clr) begin
      parity_err <= 1'b0;
    end else if (par_bad_c) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  m_s2p_hold #(
    .WORD (WORD)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .load      (load_c),
    .load_word (load_data_c),
    .ready     (word_ready),
    .word      (word_o),
    .valid     (word_valid),
    .ovf       (ovf)
  );

endmodule

// File: tb/tb_m_s_to_p.sv
// Self-checking bench for m_s_to_p (WORD=8): scoreboard of expected words,
// popped whenever the DUT hands a word to the consumer.
module tb_m_s_to_p;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic       sin;
  logic       sin_valid;
  logic [7:0] word_o;
  logic       word_valid;
  logic       word_ready;
  logic       busy;
  logic       ovf;
  logic       parity_err;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  m_s_to_p #(.WORD(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .word_o     (word_o),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .ovf        (ovf),
    .parity_err (parity_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Consumer side: a handshake seen between edges is taken at the next rising edge.
  always @(negedge clk) begin
    if (reset && !clr && word_valid && word_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'(word_valid), 32'd0);
      else chk("pop_word", 32'(word_o), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
  endtask

  // Send a frame MSB first; optional idle gaps after bits 3 and 6, optional
  // word_ready rise before the last bit, and parity override (-1 = correct).
  task automatic send_frame(input logic [7:0] w, input int gap, input bit ready_last, input int par);
    for (int k = 1; k <= 8; k++) begin
`ifndef S2P_PARITY_EN
      if (k == 8 && ready_last) word_ready = 1'b1;
`endif
      send_bit(w[8-k]);
      if (gap > 0 && (k == 3 || k == 6)) begin
        sin_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("busy_gap", 32'(busy), 32'd1);
        end
      end
    end
`ifdef S2P_PARITY_EN
    if (ready_last) word_ready = 1'b1;
    send_bit(par < 0 ? ^w : par[0]);
`endif
    sin_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; sin = 1'b0; sin_valid = 1'b0; word_ready = 1'b0;
    repeat (2) tick();
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_word", 32'(word_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    reset = 1'b1;
    tick();

    // 1: continuous frame, consumer ready
    word_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 0, 1'b0, -1);
    chk("t1_valid", 32'(word_valid), 32'd1);
    chk("t1_word", 32'(word_o), 32'hA5);
    chk("t1_idle", 32'(busy), 32'd0);
    tick();
    chk("t1_popped", 32'(word_valid), 32'd0);

    // 2: gaps after bits 3 and 6
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 2, 1'b0, -1);
    chk("t2_word", 32'(word_o), 32'hA5);
    tick();
    chk("t2_popped", 32'(word_valid), 32'd0);

    // 3: overflow, held word kept
    word_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 0, 1'b0, -1);
    send_frame(8'hC3, 0, 1'b0, -1);
    chk("t3_word", 32'(word_o), 32'h3C);
    chk("t3_ovf", 32'(ovf), 32'd1);
    chk("t3_valid", 32'(word_valid), 32'd1);
    word_ready = 1'b1;
    tick();
    chk("t3_popped", 32'(word_valid), 32'd0);
    chk("t3_ovf_sticky", 32'(ovf), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t3_ovf_clr", 32'(ovf), 32'd0);

    // 4: completion while full with same-edge pop
    word_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 0, 1'b0, -1);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 0, 1'b1, -1);
    chk("t4_valid", 32'(word_valid), 32'd1);
    chk("t4_word", 32'(word_o), 32'hC3);
    chk("t4_ovf", 32'(ovf), 32'd0);
    tick();
    chk("t4_popped", 32'(word_valid), 32'd0);

    // 5a: reset mid-frame
    for (int k = 0; k < 4; k++) send_bit(1'b1);
    sin_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("t5_rst_valid", 32'(word_valid), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 0, 1'b0, -1);
    chk("t5_rst_word", 32'(word_o), 32'h81);
    tick();

    // 5b: clr mid-frame
    for (int k = 0; k < 4; k++) send_bit(1'b1);
    sin_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 0, 1'b0, -1);
    chk("t5_clr_word", 32'(word_o), 32'h81);
    tick();

`ifdef S2P_PARITY_EN
    // 6: parity good, bad, sticky, clear
    exp_q.push_back(8'h07);
    send_frame(8'h07, 0, 1'b0, 1);
    chk("t6_good", 32'(parity_err), 32'd0);
    tick();
    exp_q.push_back(8'h07);
    send_frame(8'h07, 0, 1'b0, 0);
    chk("t6_word", 32'(word_o), 32'h07);
    chk("t6_bad", 32'(parity_err), 32'd1);
    tick();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 0, 1'b0, -1);
    chk("t6_sticky", 32'(parity_err), 32'd1);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_clr", 32'(parity_err), 32'd0);
`else
    chk("perr_tied", 32'(parity_err), 32'd0);
`endif

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
